// File: rtl/coeff_bank_loader.sv
// Single-buffered coefficient bank: loads S serial coefficients, then drives the
// S-to-1 mux select through the block in natural or bit-reversed order.
module coeff_bank_loader #(
  parameter int N = 64,
  parameter int S = 64,
  localparam int SW = $clog2(S)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bitrev_mode,
  input  logic [N-1:0]    in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [S*N-1:0]  bank,
  output logic [SW-1:0]   sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy
);

  typedef enum logic {LOAD, DRAIN} state_t;

  localparam logic [SW-1:0] LAST = SW'(S - 1);

  state_t                 state;
  logic [SW-1:0]          wr_cnt;
  logic [SW-1:0]          rd_cnt;
  logic [SW-1:0]          rd_nxt;
  logic                   mode_q;
  logic [S-1:0][N-1:0]    bank_q;

  function automatic logic [SW-1:0] bit_rev(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    for (int b = 0; b < SW; b++) r[b] = v[SW-1-b];
    return r;
  endfunction

  assign rd_nxt   = rd_cnt + 1'b1;
  assign in_ready = (state == LOAD) & ~rst;
  assign bank     = bank_q;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      mode_q    <= 1'b0;
      // NOTE: the bank is deliberately cleared so an abandoned block never
      // reaches the mux; this costs a reset on every storage bit.
      bank_q    <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            bank_q[wr_cnt] <= in_data;
            busy           <= 1'b1;
            if (wr_cnt == '0) mode_q <= bitrev_mode;
            if (wr_cnt == LAST) begin
              wr_cnt    <= '0;
              rd_cnt    <= '0;
              state     <= DRAIN;
              sel       <= '0;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_cnt == LAST) begin
              // sel keeps its last value; consumers qualify it with out_valid
              rd_cnt    <= '0;
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              rd_cnt   <= rd_nxt;
              sel      <= mode_q ? bit_rev(rd_nxt) : rd_nxt;
              out_last <= (rd_nxt == LAST);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_bank_loader.sv
// Bench for coeff_bank_loader (N=16, S=8): table-driven blocks feeding a
// scoreboard of expected {sel, mux data, last} per output transfer.
module tb_coeff_bank_loader;
  localparam int N  = 16;
  localparam int S  = 8;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            bitrev_mode;
  logic [N-1:0]    in_data;
  logic            in_valid;
  logic            in_ready;
  logic [S*N-1:0]  bank;
  logic [SW-1:0]   sel;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;
  logic [N-1:0]    mux_out;

  coeff_bank_loader #(.N(N), .S(S)) dut (
    .clk(clk), .rst(rst), .bitrev_mode(bitrev_mode), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .bank(bank), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  assign mux_out = bank[int'(sel)*N +: N];

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sel;
    logic [N-1:0]  data;
    logic          last;
  } exp_t;

  typedef struct {
    logic          mode;
    logic [N-1:0]  base;
    logic [23:0]   order;
    int            gap_pct;
    int            stall_at;
    int            stall_len;
  } vec_t;

  localparam logic [23:0] NAT = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] REV = {3'd7, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0};

  exp_t          q[$];
  logic [N-1:0]  acc[S];
  int            acc_cnt;
  logic [23:0]   cur_order;
  logic          prev_stall;
  logic [SW-1:0] prev_sel;
  int            popped;
  int            cycles;
  int            n_tests;
  int            n_fail;
  vec_t          vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check current outputs, score this cycle's transfers, advance.
  task automatic step();
    exp_t e;
    check("out_valid", out_valid, q.size() != 0);
    check("in_ready", in_ready, q.size() == 0);
    check("busy", busy, (q.size() != 0) || (acc_cnt != 0));
    if (prev_stall) check("stall_sel_hold", sel, prev_sel);
    prev_stall = out_valid && !out_ready;
    prev_sel   = sel;
    if (out_valid && out_ready && q.size() != 0) begin
      e = q.pop_front();
      check("out_sel", sel, e.sel);
      check("out_data", mux_out, e.data);
      check("out_last", out_last, e.last);
      popped++;
    end
    if (in_valid && in_ready) begin
      acc[acc_cnt] = in_data;
      acc_cnt++;
      if (acc_cnt == S) begin
        for (int k = 0; k < S; k++) begin
          e.sel  = cur_order[3*k +: 3];
          e.data = acc[e.sel];
          e.last = (k == S - 1);
          q.push_back(e);
        end
        acc_cnt = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cycles++;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    #1;
    check("in_ready_in_rst", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_sel", sel, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_bank_zero", bank == '0, 1);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    q.delete();
    acc_cnt    = 0;
    prev_stall = 1'b0;
  endtask

  // bitrev_mode is the requested mode only on the first coefficient, inverted after.
  task automatic load_vals(input logic [N-1:0] base, input logic mode, input int n, input int gap_pct);
    logic accepted;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
        in_valid    = 1'b0;
        in_data     = 16'($urandom);
        bitrev_mode = 1'($urandom_range(1));
        step();
      end
      in_valid    = 1'b1;
      in_data     = base + 16'(i);
      bitrev_mode = (i == 0) ? mode : !mode;
      accepted    = 1'b0;
      for (int w = 0; w < 50 && !accepted; w++) begin
        accepted = in_ready;
        step();
      end
      check("load_accept", accepted, 1);
    end
    in_valid    = 1'b0;
    bitrev_mode = 1'b0;
  endtask

  // Drains with junk on the input side; stops early once stop_at outputs are taken.
  task automatic drain(input int stall_at, input int stall_len, input int stop_at);
    int stalls = 0;
    popped = 0;
    for (int c = 0; c < 100 && q.size() != 0 && popped < stop_at; c++) begin
      out_ready = !(popped == stall_at - 1 && stalls < stall_len);
      if (!out_ready) stalls++;
      in_valid    = 1'($urandom_range(1));
      in_data     = 16'($urandom);
      bitrev_mode = 1'($urandom_range(1));
      step();
    end
    check("drain_done", (q.size() == 0) || (popped >= stop_at), 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int c0;
    n_tests = 0; n_fail = 0; acc_cnt = 0; popped = 0; cycles = 0;
    prev_stall = 1'b0; prev_sel = '0; cur_order = NAT;
    rst = 1'b1; bitrev_mode = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;

    vecs[0] = '{mode: 1'b0, base: 16'h0010, order: NAT, gap_pct: 0,  stall_at: 0, stall_len: 0};
    vecs[1] = '{mode: 1'b1, base: 16'h0010, order: REV, gap_pct: 0,  stall_at: 0, stall_len: 0};
    vecs[2] = '{mode: 1'b0, base: 16'h0020, order: NAT, gap_pct: 40, stall_at: 4, stall_len: 3};
    vecs[3] = '{mode: 1'b1, base: 16'h0030, order: REV, gap_pct: 0,  stall_at: 0, stall_len: 0};
    vecs[4] = '{mode: 1'b0, base: 16'h0040, order: NAT, gap_pct: 0,  stall_at: 0, stall_len: 0};

    @(negedge clk);
    do_reset();

    for (int v = 0; v < 5; v++) begin
      cur_order = vecs[v].order;
      c0 = cycles;
      load_vals(vecs[v].base, vecs[v].mode, S, vecs[v].gap_pct);
      drain(vecs[v].stall_at, vecs[v].stall_len, 99);
      if (vecs[v].gap_pct == 0 && vecs[v].stall_len == 0)
        check("block_cycles", cycles - c0, 2 * S);
    end

    // Reset part-way through a load; the fresh block must start at slot 0.
    cur_order = NAT;
    load_vals(16'h0050, 1'b1, 5, 0);
    do_reset();
    load_vals(16'h00A0, 1'b0, S, 0);
    drain(0, 0, 99);

    // Reset while the 3rd output is presented.
    cur_order = REV;
    load_vals(16'h0060, 1'b1, S, 0);
    drain(0, 0, 2);
    check("third_out_sel", sel, 3'd2);
    do_reset();

    cur_order = NAT;
    load_vals(16'h0070, 1'b0, S, 20);
    drain(0, 0, 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/coeff_bank_loader.md
Name: coeff_bank_loader

Overview:
- Buffers one block of S coefficients arriving serially on a valid/ready stream.
- Presents the block as a flat bus that drives the data input of the S-to-1 coefficient select mux.
- Drives the mux select through all S entries, in natural or bit-reversed order, and qualifies the mux output with a valid/ready handshake toward the downstream butterfly stage.
- Single-buffered: load and drain phases alternate.

Parameters:
- N, 64, coefficient width in bits.
- S, 64, coefficients per block; power of two, at least 2.
- SW, $clog2(S), select/counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bitrev_mode  input  1  read order for the block being loaded: 0 = natural, 1 = bit-reversed.
- in_data  input  N  incoming coefficient.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts a coefficient this cycle.
- bank  output  S*N  flat coefficient bank; slot k occupies bits [N*k +: N]. Connects to the mux data input.
- sel  output  SW  mux select. Value k selects slot k; sel[0] chooses between adjacent slots.
- out_valid  output  1  mux output at the current sel is valid.
- out_ready  input  1  downstream consumes the mux output this cycle.
- out_last  output  1  current output is the S-th of the block.
- busy  output  1  high in DRAIN, or in LOAD with wr_cnt != 0.

Behaviour:
- Reset (rst high at an edge):
  - state = LOAD, wr_cnt = 0, rd_cnt = 0, mode_q = 0.
  - All bank slots = 0.
  - After that edge: sel = 0, out_valid = 0, out_last = 0, busy = 0.
  - in_ready is forced 0 during any cycle rst is high.
  - Reset mid-load or mid-drain abandons the block with no partial output; the next accepted coefficient is slot 0.
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready. All outputs except in_ready are registered or derived from registered state only. in_ready = (state == LOAD) & ~rst.
- LOAD state:
  - in_ready = 1, out_valid = 0, out_last = 0.
  - On an input transfer: bank slot wr_cnt <= in_data, and wr_cnt increments.
  - On the transfer with wr_cnt == 0: mode_q <= bitrev_mode. bitrev_mode is ignored at all other times.
  - On the transfer with wr_cnt == S-1: wr_cnt <= 0, rd_cnt <= 0, state <= DRAIN.
  - in_valid low leaves all state unchanged; gaps are allowed anywhere.
- DRAIN state:
  - in_ready = 0; in_valid and in_data are ignored; the bank holds its contents.
  - out_valid = 1.
  - sel = rd_cnt when mode_q = 0; sel = bit-reverse of rd_cnt over SW bits when mode_q = 1 (sel[b] = rd_cnt[SW-1-b]).
  - out_last = (rd_cnt == S-1).
  - On an output transfer: rd_cnt increments. If rd_cnt == S-1: rd_cnt <= 0, state <= LOAD.
  - out_ready low holds sel and out_valid stable; there is no timeout.
- Latency and timing:
  - out_valid rises on the cycle after the S-th input transfer.
  - in_ready rises on the cycle after the output transfer with out_last = 1.
  - With both sides always ready, a block takes S load cycles plus S drain cycles (2S cycles per block).
- Within a cycle, the mux output is bank slot sel. The block adds no register on the data path; the downstream stage samples the mux output when out_valid & out_ready.
- sel holds its last DRAIN value while in LOAD. Consumers qualify it with out_valid only.

Test Plan (bench uses N=16, S=8, with the mux instantiated on bank/sel):
- Reset, then load 0x0010..0x0017 with bitrev_mode=0 and out_ready=1. Required: sel sequence 0..7, mux outputs 0x0010..0x0017, out_last only on the 8th output, in_ready high again on the next cycle.
- Same load with bitrev_mode=1 at the first transfer, then held at 0. Required: sel sequence 0,4,2,6,1,5,3,7; outputs 0x0010,0x0014,0x0012,0x0016,0x0011,0x0015,0x0013,0x0017.
- Random in_valid gaps and out_ready low for 3 cycles at the 4th output. Required: sel and out_valid held stable, no value duplicated or lost, and in_valid asserted during DRAIN does not alter the bank.
- Assert rst after 5 loads, then load 8 fresh values 0x00A0..0x00A7. Required: out_valid stays 0 until the 8th new transfer; outputs 0x00A0..0x00A7 only.
- Assert rst during DRAIN at the 3rd output. Required: out_valid = 0 and busy = 0 after that edge, bank all zero, in_ready = 1 on the next cycle.
- Two back-to-back blocks, the first bit-reversed and the second natural. Required: mode_q re-latches per block, and no cycle has in_ready and out_valid both high.
